// File: rtl/wb_slave_mem.sv
// -----------------------------------------------------------------------------
// wb_slave_mem
//
// WISHBONE rev.B2 classic-cycle slave. It is a word-addressed memory with
// byte-lane writes, a configurable number of wait states before each
// termination, and an error termination for out-of-range addresses.
//
// Optional feature (compile-time macro): WB_SLAVE_RTY_EN
//   When defined, every rty_period-th in-range transfer is answered with rty
//   instead of ack. When undefined, rty is tied low and no retry counter is
//   built.
//
// Parameters:
//   dwidth      data bus width in bits (multiple of 8)
//   awidth      address bus width in bits (byte addressing)
//   mem_aw      log2 of memory depth in words
//   wait_states extra cycles before each ack/err/rty (0..15)
//   rty_period  retry period (2..255), used only with WB_SLAVE_RTY_EN
//
// Ports:
//   clk   in   1         system clock, rising edge
//   rst   in   1         synchronous reset, active low
//   cyc   in   1         bus cycle valid
//   stb   in   1         transfer request
//   we    in   1         1 = write, 0 = read
//   sel   in   dwidth/8  byte-lane enables
//   adr   in   awidth    byte address
//   din   in   dwidth    write data from master
//   dout  out  dwidth    read data to master (holds until next read ack)
//   ack   out  1         normal termination (registered)
//   err   out  1         error termination (registered)
//   rty   out  1         retry termination (registered, 0 without the macro)
// -----------------------------------------------------------------------------
module wb_slave_mem #(
    parameter int dwidth      = 32,
    parameter int awidth      = 32,
    parameter int mem_aw      = 8,
    parameter int wait_states = 0,
    parameter int rty_period  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cyc,
    input  logic                stb,
    input  logic                we,
    input  logic [dwidth/8-1:0] sel,
    input  logic [awidth-1:0]   adr,
    input  logic [dwidth-1:0]   din,
    output logic [dwidth-1:0]   dout,
    output logic                ack,
    output logic                err,
    output logic                rty
);

    localparam int nlanes = dwidth / 8;
    localparam int lb     = $clog2(nlanes);
    localparam int depth  = 1 << mem_aw;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        wcnt;
    logic              req;
    logic              oor;
    logic              resp_go;
    logic              rty_hit;
    logic              do_ack;
    logic              do_write;
    logic [mem_aw-1:0] widx;

    logic [dwidth-1:0] mem [depth];

    // ------------------------------------------------------------------
    // Address decode: word index and out-of-range detection
    // ------------------------------------------------------------------
    assign widx = adr[lb +: mem_aw];

    generate
        if (awidth > lb + mem_aw) begin : g_oor
            assign oor = |adr[awidth-1:lb+mem_aw];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end

        // Byte-offset bits inside a word carry no meaning for this slave.
        if (lb > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^adr[lb-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response decision for the current edge
    // ------------------------------------------------------------------
    always_comb begin
        req     = cyc & stb;
        resp_go = 1'b0;
        case (state)
            IDLE:    resp_go = req && (wait_states == 0);
            WAIT:    resp_go = req && (wcnt == '0);
            default: resp_go = 1'b0;
        endcase
        // err wins over rty; rty wins over ack.
        do_ack   = resp_go && !oor && !rty_hit;
        do_write = do_ack && we;
    end

    // ------------------------------------------------------------------
    // Control FSM, wait counter, ack/err and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= '0;
            ack   <= 1'b0;
            err   <= 1'b0;
            dout  <= '0;
        end else begin
            ack <= do_ack;
            err <= resp_go && oor;
            if (do_ack && !we) begin
                dout <= mem[widx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (wait_states == 0) begin
                            state <= RESP;
                        end else begin
                            wcnt  <= 4'(wait_states - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A dropped cyc or stb abandons the transfer silently.
                    if (!req) begin
                        state <= IDLE;
                    end else if (wcnt == '0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    // Always pass through IDLE so a held stb cannot be
                    // re-acknowledged on consecutive cycles.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory array: byte-lane write at the ack edge, never during reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            for (int unsigned i = 0; i < nlanes; i++) begin
                if (sel[i]) begin
                    mem[widx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional retry generation
    // ------------------------------------------------------------------
`ifdef WB_SLAVE_RTY_EN
    logic [7:0] rcnt;

    // The counter value before the increment selects the retried transfer,
    // so with period N the N-th in-range transfer receives rty.
    always_comb begin
        rty_hit = (rcnt == 8'(rty_period - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt <= '0;
            rty  <= 1'b0;
        end else begin
            rty <= resp_go && !oor && rty_hit;
            if (resp_go && !oor) begin
                rcnt <= rty_hit ? 8'd0 : rcnt + 8'd1;
            end
        end
    end
`else
    always_comb begin
        rty_hit = 1'b0;
    end

    assign rty = 1'b0;
`endif

endmodule
